// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage RV32I pipeline.
//   Owns PCF, a single-outstanding instruction-memory port, a one-entry
//   fetch buffer and the IF/ID register.
// Ports:
//   clk, rst               clock / async active-high reset
//   StallF, StallD, FlushD hazard-unit controls
//   PCSrcE, PCTargetE      E-stage redirect
//   imem_req, imem_addr    request (accepted in the cycle it is high)
//   imem_rvalid, imem_rdata response
//   PCF                    current fetch PC
//   InstrD, PCD, PCPlus4D, ValidD  IF/ID register outputs
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {sIdle, sIssue, sWait, sHave} state_t;

  state_t      state, stateNext;
  logic        kill, killNext;
  logic [31:0] bufInstr, bufNext;
  logic [31:0] pcNext;
  logic [31:0] pcPlus4F;
  logic [31:0] redirectPc;
  logic        avail;
  logic [31:0] availInstr;
  logic        deliver;

  assign pcPlus4F   = PCF + 32'd4;  // wraps mod 2^32
  assign redirectPc = PCTargetE & 32'hFFFF_FFFC;

  // An instruction is available from a live (non-killed) response or the buffer.
  assign avail      = (state == sHave) || (state == sWait && imem_rvalid && !kill);
  assign availInstr = (state == sHave) ? bufInstr : imem_rdata;
  assign deliver    = avail && !StallF && !StallD && !FlushD && !PCSrcE;

  assign imem_req  = (state == sIssue);
  assign imem_addr = PCF;

  always_comb begin
    stateNext = state;
    pcNext    = PCF;
    killNext  = kill;
    bufNext   = bufInstr;
    case (state)
      sIdle: stateNext = sIssue;
      sIssue: begin
        // The request still goes out; its response will be dropped via kill.
        stateNext = sWait;
        if (PCSrcE) begin
          killNext = 1'b1;
          pcNext   = redirectPc;
        end
      end
      sWait: begin
        if (PCSrcE) begin
          pcNext = redirectPc;
          if (imem_rvalid) begin
            killNext  = 1'b0;
            stateNext = sIssue;
          end else begin
            killNext = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            // Stale response: PCF already points at the redirect target.
            killNext  = 1'b0;
            stateNext = sIssue;
          end else if (deliver) begin
            pcNext    = pcPlus4F;
            stateNext = sIssue;
          end else begin
            bufNext   = imem_rdata;
            stateNext = sHave;
          end
        end
      end
      sHave: begin
        // Leaving HAVE is what discards the buffer; no separate valid bit.
        if (PCSrcE) begin
          pcNext    = redirectPc;
          stateNext = sIssue;
        end else if (deliver) begin
          pcNext    = pcPlus4F;
          stateNext = sIssue;
        end
      end
      default: stateNext = sIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= sIdle;
      PCF      <= RESET_PC;
      kill     <= 1'b0;
      bufInstr <= 32'd0;
    end else begin
      state    <= stateNext;
      PCF      <= pcNext;
      kill     <= killNext;
      bufInstr <= bufNext;
    end
  end

  // IF/ID: flush > stall > deliver > bubble. Bubbles keep PCD/PCPlus4D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (deliver) begin
        InstrD   <= availInstr;
        PCD      <= PCF;
        PCPlus4D <= pcPlus4F;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0;
  logic [31:0] PCTargetE = 0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 0;
  logic [31:0] imem_rdata = 0;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sf, sd, fd, br;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] rd;
    logic        eReq;
    logic [31:0] ePC;
    logic        eValid;
    logic [31:0] eInstr, ePCD, ePP4;
  } vec_t;

  function automatic vec_t mk(logic sf, logic sd, logic fd, logic br, logic [31:0] tgt,
                              logic rv, logic [31:0] rd, logic eReq, logic [31:0] ePC,
                              logic eValid, logic [31:0] eInstr, logic [31:0] ePCD,
                              logic [31:0] ePP4);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fd = fd; v.br = br; v.tgt = tgt; v.rv = rv; v.rd = rd;
    v.eReq = eReq; v.ePC = ePC; v.eValid = eValid; v.eInstr = eInstr;
    v.ePCD = ePCD; v.ePP4 = ePP4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sf, sd, fd, br, input logic [31:0] tgt,
                       input logic rv, input logic [31:0] rd);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = br; PCTargetE = tgt;
    imem_rvalid = rv; imem_rdata = rd;
  endtask

  // One cycle: inputs after the edge, compare at negedge, then advance.
  task automatic cyc(input string tag, input vec_t v);
    drive(v.sf, v.sd, v.fd, v.br, v.tgt, v.rv, v.rd);
    @(negedge clk);
    chk({tag, ".req"},    {31'd0, imem_req}, {31'd0, v.eReq});
    chk({tag, ".PCF"},    PCF, v.ePC);
    if (v.eReq) chk({tag, ".addr"}, imem_addr, v.ePC);
    chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, v.eValid});
    chk({tag, ".InstrD"}, InstrD, v.eInstr);
    chk({tag, ".PCD"},    PCD, v.ePCD);
    chk({tag, ".PCP4D"},  PCPlus4D, v.ePP4);
    @(posedge clk); #1;
  endtask

  // Transaction-level reference model
  logic        mIdle, mIssue, mOut, mKill, mBufV, mValid;
  logic [31:0] mBufD, mPC, mInstr, mPCD, mPP4;

  task automatic modelReset();
    mIdle = 1; mIssue = 0; mOut = 0; mKill = 0; mBufV = 0; mBufD = 0;
    mPC = 0; mInstr = NOP; mPCD = 0; mPP4 = 0; mValid = 0;
  endtask

  task automatic modelStep(input logic sf, sd, fd, br, input logic [31:0] tgt,
                           input logic rv, input logic [31:0] rd);
    logic resp, avail, dlv;
    logic [31:0] d;
    resp  = mOut && rv;
    avail = mBufV || (resp && !mKill);
    d     = mBufV ? mBufD : rd;
    dlv   = avail && !(sf || sd || fd || br);
    if (fd) begin mInstr = NOP; mValid = 0; end
    else if (!sd) begin
      if (dlv) begin mInstr = d; mPCD = mPC; mPP4 = mPC + 4; mValid = 1; end
      else begin mInstr = NOP; mValid = 0; end
    end
    if (mIdle) begin mIdle = 0; mIssue = 1; end
    else if (mIssue) begin
      mIssue = 0; mOut = 1;
      if (br) begin mKill = 1; mPC = tgt & 32'hFFFF_FFFC; end
    end else if (br) begin
      mPC = tgt & 32'hFFFF_FFFC; mBufV = 0;
      if (resp) begin mOut = 0; mKill = 0; mIssue = 1; end
      else if (mOut) mKill = 1;
      else mIssue = 1;
    end else if (resp && mKill) begin mOut = 0; mKill = 0; mIssue = 1; end
    else if (dlv) begin mPC = mPC + 4; mBufV = 0; mOut = 0; mIssue = 1; end
    else if (avail) begin mBufV = 1; mBufD = d; mOut = 0; end
  endtask

  localparam logic [31:0] I0 = 32'h0010_0093, I1 = 32'h0020_0113, I2 = 32'h0030_0193;
  localparam logic [31:0] IA = 32'h00A0_0093, I5 = 32'h0050_0293, I6 = 32'h0060_0313;
  localparam logic [31:0] I7 = 32'h0070_0393, I8 = 32'h0080_0413, I9 = 32'h0090_0493;

  vec_t tbl[18];

  initial begin
    // cycle-by-cycle: latency-1 stream, StallF/StallD over a response, redirect in WAIT
    tbl[0]  = mk(0,0,0,0,0,     0,0,           0,32'h0,  0,NOP,32'h0,32'h0);
    tbl[1]  = mk(0,0,0,0,0,     0,0,           1,32'h0,  0,NOP,32'h0,32'h0);
    tbl[2]  = mk(0,0,0,0,0,     1,I0,          0,32'h0,  0,NOP,32'h0,32'h0);
    tbl[3]  = mk(0,0,0,0,0,     0,0,           1,32'h4,  1,I0, 32'h0,32'h4);
    tbl[4]  = mk(0,0,0,0,0,     1,I1,          0,32'h4,  0,NOP,32'h0,32'h4);
    tbl[5]  = mk(0,0,0,0,0,     0,0,           1,32'h8,  1,I1, 32'h4,32'h8);
    tbl[6]  = mk(0,0,0,0,0,     1,I2,          0,32'h8,  0,NOP,32'h4,32'h8);
    tbl[7]  = mk(0,0,0,0,0,     0,0,           1,32'hC,  1,I2, 32'h8,32'hC);
    tbl[8]  = mk(1,1,0,0,0,     1,IA,          0,32'hC,  0,NOP,32'h8,32'hC);
    tbl[9]  = mk(1,1,0,0,0,     0,0,           0,32'hC,  0,NOP,32'h8,32'hC);
    tbl[10] = mk(1,1,0,0,0,     0,0,           0,32'hC,  0,NOP,32'h8,32'hC);
    tbl[11] = mk(0,0,0,0,0,     0,0,           0,32'hC,  0,NOP,32'h8,32'hC);
    tbl[12] = mk(0,0,0,0,0,     0,0,           1,32'h10, 1,IA, 32'hC,32'h10);
    tbl[13] = mk(0,0,0,1,32'h107,0,0,          0,32'h10, 0,NOP,32'hC,32'h10);
    tbl[14] = mk(0,0,0,0,0,     1,32'hDEADBEEF,0,32'h104,0,NOP,32'hC,32'h10);
    tbl[15] = mk(0,0,0,0,0,     0,0,           1,32'h104,0,NOP,32'hC,32'h10);
    tbl[16] = mk(0,0,0,0,0,     1,I5,          0,32'h104,0,NOP,32'hC,32'h10);
    tbl[17] = mk(0,1,0,0,0,     0,0,           1,32'h108,1,I5, 32'h104,32'h108);

    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 18; i++) cyc($sformatf("tbl%0d", i), tbl[i]);

    // HAVE buffer + redirect + FlushD + StallD same cycle
    cyc("have", mk(0,1,0,0,0,      1,I6,0, 32'h108,1,I5, 32'h104,32'h108));
    cyc("flbr", mk(0,1,1,1,32'h200,0,0, 0, 32'h108,1,I5, 32'h104,32'h108));
    cyc("tgt",  mk(0,0,0,0,0,      0,0, 1, 32'h200,0,NOP,32'h104,32'h108));
    cyc("tgtw", mk(0,0,0,0,0,      1,I7,0, 32'h200,0,NOP,32'h104,32'h108));
    // redirect in ISSUE to the top word, then wrap
    cyc("isbr", mk(0,0,0,1,32'hFFFF_FFFE,0,0,1,32'h204,1,I7,32'h200,32'h204));
    cyc("kil",  mk(0,0,0,0,0,1,32'hBAD0_0001,0,32'hFFFF_FFFC,0,NOP,32'h200,32'h204));
    cyc("top",  mk(0,0,0,0,0,0,0, 1,32'hFFFF_FFFC,0,NOP,32'h200,32'h204));
    cyc("topw", mk(0,0,0,0,0,1,I8,0,32'hFFFF_FFFC,0,NOP,32'h200,32'h204));
    cyc("wrap", mk(0,0,0,0,0,0,0, 1,32'h0,1,I8,32'hFFFF_FFFC,32'h0));
    cyc("wait", mk(0,0,0,0,0,0,0, 0,32'h0,0,NOP,32'hFFFF_FFFC,32'h0));
    // reset while waiting; response arrives in IDLE
    rst = 1;
    cyc("rst",  mk(0,0,0,0,0,0,0, 0,32'h0,0,NOP,32'h0,32'h0));
    rst = 0;
    cyc("idle", mk(0,0,0,0,0,1,32'hBAD0_0002,0,32'h0,0,NOP,32'h0,32'h0));
    cyc("iss0", mk(0,0,0,0,0,0,0, 1,32'h0,0,NOP,32'h0,32'h0));
    cyc("rsp0", mk(0,0,0,0,0,1,I9,0,32'h0,0,NOP,32'h0,32'h0));
    cyc("dlv0", mk(0,0,0,0,0,0,0, 1,32'h4,1,I9,32'h0,32'h4));

    // randomized run against the reference model, memory latency 1..3
    begin
      logic        memPend, rv, sf, sd, fd, br;
      logic [31:0] memAddr, rd, tgt;
      int          memCnt;
      rst = 1; drive(0,0,0,0,0,0,0);
      @(posedge clk); #1 rst = 0;
      modelReset();
      memPend = 0; memCnt = 0; memAddr = 0;
      for (int c = 0; c < 3000; c++) begin
        sf  = ($urandom_range(0, 3) == 0);
        sd  = ($urandom_range(0, 3) == 0);
        fd  = ($urandom_range(0, 7) == 0);
        br  = ($urandom_range(0, 9) == 0);
        tgt = $urandom;
        if ($urandom_range(0, 49) == 0) tgt = 32'hFFFF_FFFC;
        rv  = memPend && (memCnt == 0);
        rd  = rv ? (memAddr ^ 32'h1357_9BDF) : $urandom;
        drive(sf, sd, fd, br, tgt, rv, rd);
        @(negedge clk);
        chk("rnd.req",    {31'd0, imem_req}, {31'd0, mIssue});
        chk("rnd.PCF",    PCF, mPC);
        chk("rnd.ValidD", {31'd0, ValidD}, {31'd0, mValid});
        chk("rnd.InstrD", InstrD, mInstr);
        chk("rnd.PCD",    PCD, mPCD);
        chk("rnd.PCP4D",  PCPlus4D, mPP4);
        if (rv) memPend = 0;
        else if (memPend) memCnt--;
        if (mIssue) begin
          memPend = 1; memCnt = $urandom_range(0, 2); memAddr = mPC;
        end
        modelStep(sf, sd, fd, br, tgt, rv, rd);
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
